prime_candidate_gen: RTL and testbench

- Upstream feeder for the Miller-Rabin primality tester in the RSA key-generation path.
- Draws pseudo-random odd candidates of WORD_WIDTH/2 bits with the MSB set, from a seeded Galois LFSR.
- Rejects a candidate by bit-serial trial division by 3, 5, 7, 11 and 13; survivors are handed to the tester.
- Repeats until the tester reports prime (output P or Q) or the attempt budget runs out.

---
 rtl/prime_candidate_gen.sv | 151 +++++++++++++++
 tb/tb_prime_candidate_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_candidate_gen.sv
// Draws odd, MSB-set candidates from a Galois LFSR and rejects small-prime multiples
// with a bit-serial sieve. Survivors are offered to an external Miller-Rabin tester.
module prime_candidate_gen #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH/2-1:0] LFSR_TAPS = 16'hB400,
    parameter int unsigned MAX_ATTEMPTS = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WORD_WIDTH/2-1:0]   seed,
    input  logic [1:0]                security_parameter,
    output logic                      busy,
    output logic                      done,
    output logic                      fail,
    output logic [WORD_WIDTH/2-1:0]   prime,
    output logic [7:0]                attempts,
    output logic                      mr_enable,
    output logic [WORD_WIDTH/2-1:0]   mr_n,
    output logic [1:0]                mr_security_parameter,
    input  logic                      mr_done,
    input  logic                      mr_is_prime
);

    localparam int H  = WORD_WIDTH / 2;
    localparam int BW = $clog2(H);
    localparam logic [H-1:0] ONE        = {{(H-1){1'b0}}, 1'b1};
    localparam logic [H-1:0] CAND_FORCE = {1'b1, {(H-2){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        IDLE, DRAW, SIEVE, CHECK, MR_START, MR_WAIT, NEXT, FOUND, S_FAIL
    } state_t;

    state_t          state;
    logic [H-1:0]    lfsr;
    logic [H-1:0]    lfsr_next;
    logic [BW-1:0]   bit_idx;
    logic [3:0]      r3, r5, r7, r11, r13;
    logic            sieve_hit;

    // One step of 2r+b mod p; r < p guarantees 2r+b < 2p, so one subtract suffices.
    function automatic logic [3:0] res_step(input logic [3:0] r, input logic b,
                                            input logic [4:0] p);
        logic [4:0] t;
        t = {r, b};
        return (t >= p) ? 4'(t - p) : t[3:0];
    endfunction

    always_comb begin
        lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        sieve_hit = (r3 == 4'd0) || (r5 == 4'd0) || (r7 == 4'd0) ||
                    (r11 == 4'd0) || (r13 == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                 <= IDLE;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            fail                  <= 1'b0;
            mr_enable             <= 1'b0;
            prime                 <= '0;
            attempts              <= '0;
            mr_n                  <= '0;
            mr_security_parameter <= '0;
            lfsr                  <= ONE;
            bit_idx               <= '0;
            r3                    <= '0;
            r5                    <= '0;
            r7                    <= '0;
            r11                   <= '0;
            r13                   <= '0;
        end else begin
            done      <= 1'b0;
            fail      <= 1'b0;
            mr_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr                  <= (seed == '0) ? ONE : seed;
                        attempts              <= '0;
                        prime                 <= '0;
                        mr_security_parameter <= security_parameter;
                        busy                  <= 1'b1;
                        state                 <= DRAW;
                    end
                end
                DRAW: begin
                    lfsr     <= lfsr_next;
                    mr_n     <= lfsr_next | CAND_FORCE;
                    attempts <= 8'(attempts + 8'd1);
                    r3       <= '0;
                    r5       <= '0;
                    r7       <= '0;
                    r11      <= '0;
                    r13      <= '0;
                    bit_idx  <= BW'(H - 1);
                    state    <= SIEVE;
                end
                SIEVE: begin
                    r3  <= res_step(r3,  mr_n[bit_idx], 5'd3);
                    r5  <= res_step(r5,  mr_n[bit_idx], 5'd5);
                    r7  <= res_step(r7,  mr_n[bit_idx], 5'd7);
                    r11 <= res_step(r11, mr_n[bit_idx], 5'd11);
                    r13 <= res_step(r13, mr_n[bit_idx], 5'd13);
                    if (bit_idx == '0) begin
                        state <= CHECK;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                CHECK: begin
                    if (sieve_hit) begin
                        state <= NEXT;
                    end else begin
                        mr_enable <= 1'b1;
                        state     <= MR_START;
                    end
                end
                MR_START: begin
                    state <= MR_WAIT;
                end
                MR_WAIT: begin
                    if (mr_done) begin
                        if (mr_is_prime) begin
                            prime <= mr_n;
                            done  <= 1'b1;
                            state <= FOUND;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (attempts == 8'(MAX_ATTEMPTS)) begin
                        fail  <= 1'b1;
                        state <= S_FAIL;
                    end else begin
                        state <= DRAW;
                    end
                end
                FOUND, S_FAIL: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_candidate_gen.sv
// Bench for prime_candidate_gen: a search-level reference model predicts tester calls
// and the final outcome; a monitor pops and compares as the DUT produces them.
module tb_prime_candidate_gen;

    localparam int H = 16;
    localparam int MAXA = 3;
    localparam logic [15:0] TAPS = 16'hB400;

    typedef struct packed {
        logic        is_done;
        logic [15:0] prime;
        logic [7:0]  att;
    } res_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] seed;
    logic [1:0]  security_parameter;
    logic        busy, done, fail, mr_enable;
    logic [15:0] prime, mr_n;
    logic [7:0]  attempts;
    logic [1:0]  mr_security_parameter;
    logic        mr_done, mr_is_prime;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int en_cnt   = 0;

    logic [15:0] exp_q[$];
    res_t        exp_res_q[$];
    bit          stub_v_q[$];
    bit          stub_en = 1'b1;
    int          stub_delay = 4;
    int          manual_cnt = 0;
    bit          prev_en = 1'b0;

    prime_candidate_gen #(.WORD_WIDTH(32), .LFSR_TAPS(TAPS), .MAX_ATTEMPTS(MAXA)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .security_parameter(security_parameter),
        .busy(busy), .done(done), .fail(fail), .prime(prime), .attempts(attempts),
        .mr_enable(mr_enable), .mr_n(mr_n), .mr_security_parameter(mr_security_parameter),
        .mr_done(mr_done), .mr_is_prime(mr_is_prime)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // reference model: the whole search from the candidate rules
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
    endfunction

    function automatic bit passes_sieve(input logic [15:0] c);
        int primes[5] = '{3, 5, 7, 11, 13};
        for (int i = 0; i < 5; i++)
            if ((int'(c) % primes[i]) == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic predict(input logic [15:0] s, input int pct);
        logic [15:0] l;
        logic [15:0] c;
        bit v;
        res_t r;
        l = (s == 16'd0) ? 16'd1 : s;
        r = '{1'b0, 16'd0, 8'(MAXA)};
        for (int a = 1; a <= MAXA; a++) begin
            l = lfsr_step(l);
            c = l | 16'h8001;
            if (!passes_sieve(c)) continue;
            exp_q.push_back(c);
            v = ($urandom_range(99) < pct);
            stub_v_q.push_back(v);
            if (v) begin
                r = '{1'b1, c, 8'(a)};
                break;
            end
        end
        exp_res_q.push_back(r);
    endtask

    // tester stub
    always begin
        bit v;
        @(negedge clk);
        if (manual_cnt > 0 && !mr_done) begin
            mr_done     = 1'b1;
            mr_is_prime = 1'b1;
            @(negedge clk);
            mr_done     = 1'b0;
            mr_is_prime = 1'b0;
        end else if (mr_enable && stub_en) begin
            v = (stub_v_q.size() > 0) ? stub_v_q.pop_front() : 1'b0;
            repeat (stub_delay - 1) @(negedge clk);
            mr_done     = 1'b1;
            mr_is_prime = v;
            @(negedge clk);
            mr_done     = 1'b0;
            mr_is_prime = 1'b0;
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (mr_enable) begin
                en_cnt++;
                chk("mr_enable_one_cycle", 32'(prev_en), 32'd0);
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_mr_enable: mr_n 0x%0h, none expected", mr_n);
                end else begin
                    chk("mr_n", 32'(mr_n), 32'(exp_q.pop_front()));
                end
            end
            prev_en = mr_enable;
            if (done || fail) begin
                res_t r;
                if (done) done_cnt++;
                chk("done_fail_exclusive", 32'(done & fail), 32'd0);
                if (exp_res_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_result: done %0b fail %0b, none expected", done, fail);
                end else begin
                    r = exp_res_q.pop_front();
                    chk("result_kind_done", 32'(done), 32'(r.is_done));
                    chk("result_prime", 32'(prime), 32'(r.prime));
                    chk("result_attempts", 32'(attempts), 32'(r.att));
                end
            end
        end else begin
            prev_en = 1'b0;
        end
    end

    // driver tasks
    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic issue(input logic [15:0] s, input logic [1:0] sp);
        seed = s;
        security_parameter = sp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && exp_res_q.size() == 0) break;
        end
        chk({name, "_finished"}, 32'(i < budget), 32'd1);
        chk({name, "_tester_calls_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int en_before;
        int done_before;
        logic [1:0] sp_vals[5];
        rst = 1'b0; start = 1'b0; seed = '0; security_parameter = '0;
        mr_done = 1'b0; mr_is_prime = 1'b0;
        do_reset();

        // reset state
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done_fail", 32'({done, fail}), 32'd0);
        chk("reset_mr_enable", 32'(mr_enable), 32'd0);
        chk("reset_prime", 32'(prime), 32'd0);
        chk("reset_attempts", 32'(attempts), 32'd0);
        chk("reset_mr_n", 32'(mr_n), 32'd0);

        // seed 1: every candidate is sieved out, so no tester calls, then fail
        en_before = en_cnt;
        predict(16'h0001, 0);
        issue(16'h0001, 2'd1);
        wait_idle("seed1", 400);
        chk("seed1_no_mr_enable", 32'(en_cnt - en_before), 32'd0);
        chk("seed1_attempts", 32'(attempts), 32'(MAXA));
        chk("seed1_prime_zero", 32'(prime), 32'd0);

        // seed 0 behaves like seed 1
        en_before = en_cnt;
        predict(16'h0000, 0);
        issue(16'h0000, 2'd0);
        wait_idle("seed0", 400);
        chk("seed0_no_mr_enable", 32'(en_cnt - en_before), 32'd0);

        // seed 4, tester says prime: enable latency and result
        stub_delay = 10;
        predict(16'h0004, 100);
        seed = 16'h0004; security_parameter = 2'd3; start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (mr_enable) begin lat = k; break; end
        end
        chk("seed4_enable_latency", 32'(lat), 32'd19);
        chk("seed4_mr_n", 32'(mr_n), 32'h8003);
        chk("seed4_mr_sec", 32'(mr_security_parameter), 32'd3);
        wait_idle("seed4_prime", 200);
        chk("seed4_prime", 32'(prime), 32'h8003);
        chk("seed4_attempts", 32'(attempts), 32'd1);
        chk("seed4_busy_low", 32'(busy), 32'd0);

        // seed 4, tester says composite: next candidates are sieved out
        en_before = en_cnt;
        predict(16'h0004, 0);
        issue(16'h0004, 2'd2);
        wait_idle("seed4_comp", 400);
        chk("seed4_comp_one_call", 32'(en_cnt - en_before), 32'd1);
        chk("seed4_comp_attempts", 32'(attempts), 32'(MAXA));

        // reset while waiting on the tester
        stub_en = 1'b0;
        predict(16'h0004, 0);
        issue(16'h0004, 2'd1);
        lat = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (mr_enable) begin lat = 1; break; end
        end
        chk("rstwait_reached_tester", 32'(lat), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstwait_busy", 32'(busy), 32'd0);
        chk("rstwait_mr_enable", 32'(mr_enable), 32'd0);
        chk("rstwait_attempts", 32'(attempts), 32'd0);
        rst = 1'b1;
        exp_q.delete(); exp_res_q.delete(); stub_v_q.delete();
        done_before = done_cnt;
        manual_cnt++;
        repeat (15) @(negedge clk);
        chk("rstwait_no_done", 32'(done_cnt - done_before), 32'd0);
        chk("rstwait_idle", 32'(busy), 32'd0);
        stub_en = 1'b1;
        manual_cnt = 0;

        // start held for 5 cycles: one search, parameter from the accept cycle
        stub_delay = 3;
        sp_vals = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd1};
        done_before = done_cnt;
        predict(16'h0004, 100);
        seed = 16'h0004;
        for (int i = 0; i < 5; i++) begin
            security_parameter = sp_vals[i];
            start = 1'b1;
            @(negedge clk);
            if (i == 0) chk("held_busy_rises", 32'(busy), 32'd1);
            if (i == 1) chk("held_attempts_first", 32'(attempts), 32'd1);
        end
        start = 1'b0;
        wait_idle("held", 200);
        chk("held_mr_sec", 32'(mr_security_parameter), 32'd2);
        repeat (30) @(negedge clk);
        chk("held_single_search", 32'(done_cnt - done_before), 32'd1);
        chk("held_stays_idle", 32'(busy), 32'd0);

        // randomized searches
        for (int t = 0; t < 12; t++) begin
            logic [15:0] s;
            s = 16'($urandom_range(65535));
            stub_delay = $urandom_range(8, 2);
            predict(s, 50);
            issue(s, 2'($urandom_range(3)));
            wait_idle("random", 600);
            repeat ($urandom_range(3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
